// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu).
package mdu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ops that occupy the unit for a multi-cycle busy window.
    function automatic logic is_start_op(md_op_t op);
        logic hit;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: hit = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: hit = 1'b1;
`endif
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Division ops use the longer cycle count.
    function automatic logic is_div_op(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit result for mult/div (and madd-class when
// MDU_MADD_EN is defined), given the operands and the current HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_t            op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic        [2*DATA_W-1:0] acc;
    logic        [2*DATA_W-1:0] res;
    logic signed [DATA_W-1:0]   quo_s;
    logic signed [DATA_W-1:0]   rem_s;
    logic        [DATA_W-1:0]   quo_u;
    logic        [DATA_W-1:0]   rem_u;
    logic                       div0;
    logic                       div_ovf;

    // Products and quotients for every op; the op mux picks one.
    always_comb begin
        prod_s  = $signed({{DATA_W{rs_val[DATA_W-1]}}, rs_val})
                * $signed({{DATA_W{rt_val[DATA_W-1]}}, rt_val});
        prod_u  = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};
        acc     = {hi_in, lo_in};
        div0    = (rt_val == '0);
        // INT_MIN / -1 cannot be represented; the architected answer is INT_MIN rem 0.
        div_ovf = (rs_val == {1'b1, {(DATA_W-1){1'b0}}}) && (rt_val == '1);
        quo_s   = '0;
        rem_s   = '0;
        quo_u   = '0;
        rem_u   = '0;
        if (!div0) begin
            if (div_ovf) begin
                quo_s = $signed(rs_val);
                rem_s = '0;
            end else begin
                quo_s = $signed(rs_val) / $signed(rt_val);
                rem_s = $signed(rs_val) % $signed(rt_val);
            end
            quo_u = rs_val / rt_val;
            rem_u = rs_val % rt_val;
        end

        case (op)
            MD_MULT:  res = $unsigned(prod_s);
            MD_MULTU: res = prod_u;
            MD_DIV:   res = div0 ? acc : {$unsigned(rem_s), $unsigned(quo_s)};
            MD_DIVU:  res = div0 ? acc : {rem_u, quo_u};
`ifdef MDU_MADD_EN
            MD_MADD:  res = acc + $unsigned(prod_s);
            MD_MADDU: res = acc + prod_u;
            MD_MSUB:  res = acc - $unsigned(prod_s);
            MD_MSUBU: res = acc - prod_u;
`endif
            default:  res = acc;
        endcase
    end

    assign res_hi = res[2*DATA_W-1:DATA_W];
    assign res_lo = res[DATA_W-1:0];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO and the decode stall.
// The result is computed at the start edge and held in a pending register;
// HI/LO are updated only when the busy window ends.
// Optional feature macro: MDU_MADD_EN.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  md_op_t            op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              d_uses_md,
    output logic              start,
    output logic              busy,
    output logic              md_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] pend_hi, pend_lo;
    logic [DATA_W-1:0] res_hi, res_lo;
    logic              accept;
    logic              commit;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_in  (hi),
        .lo_in  (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign start    = op_valid && is_start_op(op);
    assign accept   = start && (state == IDLE);
    assign busy     = (state == RUN);
    assign md_stall = d_uses_md && (start || busy);

    // Next-state logic: load the cycle counter on accept, count down, commit at zero.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    count_nxt = is_div_op(op) ? CNT_W'(DIV_CYCLES - 1)
                                              : CNT_W'(MULT_CYCLES - 1);
                end
            end
            RUN: begin
                if (count == '0) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // HI/LO and pending result: latch on accept, publish on commit, mthi/mtlo when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            if (accept) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (op_valid && (state == IDLE)) begin
                if (op == MD_MTHI) hi <= rs_val;
                if (op == MD_MTLO) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (default 5/10 cycles).
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    md_op_t      op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .start     (start),
        .busy      (busy),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit must never present an MDU op while the unit is busy.
    always @(negedge clk) begin
        if (reset && busy) begin
            total++;
            assert (!op_valid) else begin
                bad++;
                $error("FAIL op_while_busy observed=%0b expected=0", op_valid);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle, check start, then return to a bubble.
    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input logic exp_stall);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        #1;
        chk("start", {31'd0, start}, {31'd0, exp_start});
        chk("stall_issue", {31'd0, md_stall}, {31'd0, exp_stall});
        tick();
        op_valid = 1'b0;
        op       = MD_NONE;
    endtask

    // Busy window: busy and stall held, HI/LO frozen at their prior values.
    task automatic busy_window(input int n, input logic [31:0] hi_e, input logic [31:0] lo_e,
                               input logic stall_e);
        for (int i = 0; i < n; i++) begin
            chk("busy_hi", {31'd0, busy}, 32'd1);
            chk("stall_busy", {31'd0, md_stall}, {31'd0, stall_e});
            chk("hi_frozen", hi, hi_e);
            chk("lo_frozen", lo, lo_e);
            tick();
        end
    endtask

    task automatic chk_done(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, hi_e);
        chk({tag, "_lo"}, lo, lo_e);
    endtask

    initial begin
        reset     = 1'b0;
        op_valid  = 1'b0;
        op        = MD_NONE;
        rs_val    = '0;
        rt_val    = '0;
        d_uses_md = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_done("reset", 32'h0, 32'h0);
        chk("reset_start", {31'd0, start}, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);

        // mult -1 * 2 = -2
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        busy_window(5, 32'h0, 32'h0, 1'b0);
        chk_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        busy_window(5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        chk_done("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // div 7 / -2 with mflo waiting in Decode: stall for start + 10 busy cycles
        d_uses_md = 1'b1;
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        busy_window(10, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        chk_done("div", 32'h0000_0001, 32'hFFFF_FFFD);
        chk("div_stall_release", {31'd0, md_stall}, 32'd0);
        d_uses_md = 1'b0;

        // divu 0 / 0 keeps HI/LO but still runs 10 cycles
        issue(MD_DIVU, 32'd0, 32'd0, 1'b1, 1'b0);
        busy_window(10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        chk_done("divu0", 32'h0000_0001, 32'hFFFF_FFFD);

        // INT_MIN / -1
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        busy_window(10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        chk_done("div_ovf", 32'h0, 32'h8000_0000);

        // -7 / 2 = -3 remainder -1 (remainder takes the dividend's sign)
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        busy_window(10, 32'h0, 32'h8000_0000, 1'b0);
        chk_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu 0xFFFFFFFF / 16
        issue(MD_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0);
        busy_window(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        chk_done("divu", 32'h0000_000F, 32'h0FFF_FFFF);

        // mtlo then mthi back-to-back: no busy and no stall
        d_uses_md = 1'b1;
        issue(MD_MTLO, 32'h1234, 32'd0, 1'b0, 1'b0);
        chk_done("mtlo", 32'h0000_000F, 32'h0000_1234);
        issue(MD_MTHI, 32'hABCD, 32'd0, 1'b0, 1'b0);
        chk_done("mthi", 32'h0000_ABCD, 32'h0000_1234);
        issue(MD_MFHI, 32'h5555, 32'h6666, 1'b0, 1'b0);
        chk_done("mfhi", 32'h0000_ABCD, 32'h0000_1234);
        d_uses_md = 1'b0;

        // madd-class accumulate (or a no-op when the feature is absent)
        issue(MD_MTHI, 32'h0, 32'd0, 1'b0, 1'b0);
        issue(MD_MTLO, 32'd5, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        issue(MD_MADD, 32'd3, 32'd4, 1'b1, 1'b0);
        busy_window(5, 32'h0, 32'd5, 1'b0);
        chk_done("madd", 32'h0, 32'd17);
        issue(MD_MSUB, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        busy_window(5, 32'h0, 32'd17, 1'b0);
        chk_done("msub", 32'h0, 32'd18);
`else
        issue(MD_MADD, 32'd3, 32'd4, 1'b0, 1'b0);
        chk_done("madd_off", 32'h0, 32'd5);
        issue(MD_MSUBU, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        chk_done("msubu_off", 32'h0, 32'd5);
`endif

        // reset asserted in the third busy cycle of a mult aborts it immediately
        issue(MD_MTHI, 32'h55, 32'd0, 1'b0, 1'b0);
        issue(MD_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
        tick();
        tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk_done("mid_reset", 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        chk_done("post_reset", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller, sitting beside the ALU in the Execute stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and runs mult/multu/div/divu for a fixed cycle count.
- Drives start/busy and a decode-stage stall request into the hazard unit, so MDU-dependent instructions in Decode wait until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-class ops when enabled); legal range >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- op_valid  input  1  E-stage instruction is a real (non-bubble) MDU op.
- op  input  4  MDU opcode, md_op_t from package.
- rs_val  input  32  forwarded rs operand (E stage).
- rt_val  input  32  forwarded rt operand (E stage).
- d_uses_md  input  1  D-stage instruction is any MDU op, including mfhi/mflo/mthi/mtlo.
- start  output  1  combinational: op_valid and op is mult/multu/div/divu (or madd-class).
- busy  output  1  registered: an operation is in flight.
- md_stall  output  1  combinational: d_uses_md & (start | busy); ORed into the pipeline stall.
- hi  output  32  architectural HI, read by mfhi.
- lo  output  32  architectural LO, read by mflo.

Behaviour:
- Reset state: state=IDLE, count=0, busy=0, hi=0, lo=0, pending result=0. Async assertion takes effect immediately.
- Reset mid-operation aborts the op; HI/LO stay 0.
- States:
  - IDLE, busy=0.
  - RUN, busy=1, count decrements every cycle.
- IDLE -> RUN on the edge where start=1:
  - operands are sampled at that edge;
  - the full result is computed and latched into pending hi/lo at that edge;
  - count is loaded with N-1, where N is MULT_CYCLES or DIV_CYCLES.
- RUN with count!=0: count decrements.
- RUN with count==0: hi/lo take the pending values, state goes to IDLE.
- Latency: busy is high for exactly N cycles after the start edge. The new HI/LO are visible the cycle busy falls.
- mthi/mtlo in IDLE: hi (or lo) takes rs_val at the edge; no busy cycle.
- mfhi/mflo: no state change; the datapath reads the hi/lo outputs.
- Any op_valid while busy=1 is ignored. The hazard unit guarantees this never happens; the bench checks it with an assertion.
- mult: signed 64-bit product, {hi,lo}. multu: unsigned.
- div: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend. divu: unsigned.
- Divisor 0: HI/LO are left unchanged, but the op still occupies DIV_CYCLES busy cycles.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- md_stall holds the D-stage MDU op through the start cycle and all busy cycles. It releases in the cycle busy deasserts, which is the cycle HI/LO are final.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, adds madd/maddu/msub/msubu:
  - {hi,lo} +/- the signed or unsigned 64-bit product of rs_val and rt_val;
  - the accumulate base is the hi/lo value at the start edge;
  - they take MULT_CYCLES and stall exactly like mult.
- When undefined, these opcodes behave as no-ops: start=0 and no state change.

Decomposition:
- Package mdu_pkg holds:
  - md_op_t, 4-bit: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12;
  - state enum {IDLE, RUN};
  - function is_start_op(op).
- One natural sub-module, mdu_arith: purely combinational, computing the 64-bit result from op, rs, rt and the current hi/lo. The FSM, counter and registers remain in mdu_ctrl.

Test Plan:
- mult rs=0xFFFFFFFF rt=2 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during busy.
- multu rs=0xFFFFFFFF rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div 7 / 0xFFFFFFFE (-2) -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0x00000001. divu 0 by 0 keeps the prior hi/lo, and busy is still 10 cycles.
- div issued with d_uses_md=1 (mflo behind it) -> md_stall high for 11 cycles (start plus 10 busy), released the cycle lo is final.
- mtlo 0x1234 then mthi 0xABCD back-to-back -> lo=0x1234, hi=0xABCD with no busy or stall. Reset pulsed in the 3rd busy cycle of mult -> busy=0, hi=lo=0 immediately.
- MDU_MADD_EN: hi=0, lo=5, then madd rs=3 rt=4 -> after 5 cycles lo=17, hi=0. Without the macro -> hi/lo unchanged, start=0.
